// File: rtl/bstream_pkg.sv
// Shared types and helpers for the pulse-density bitstream generator.
// Lane phase offsets spread the carries of parallel lanes across the frame.
package bstream_pkg;

  typedef enum logic {IDLE, RUN} bsg_state_t;

  function automatic int unsigned lane_phase(
    input int unsigned k,
    input int unsigned dw,
    input int unsigned lanes
  );
    return ((k << dw) / lanes) & ((32'd1 << dw) - 32'd1);
  endfunction

endpackage

// File: rtl/bstream_gen_if.sv
// Value input handshake of the bitstream generator.
// Transfer happens on a rising edge with in_valid && in_ready.
interface bstream_gen_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/bstream_gen_sd_lane.sv
// First-order sigma-delta lane: the carry out of acc + value is the sample.
// load presets the phase offset and wins over step.
module sd_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] phase,
  input  logic [DATA_W-1:0] value,
  output logic              sample
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W:0]   sum;

  assign sum    = {1'b0, acc} + {1'b0, value};
  assign sample = sum[DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= phase;
    end else if (step) begin
      acc <= sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/bstream_gen.sv
// Pulse-density bitstream generator: frame FSM, active/pending value
// registers, frame counter and registered output strobes.
module bstream_gen
  import bstream_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LANES      = 2,
  parameter int FRAME_LOG2 = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  bstream_gen_if.slave     src,
  output logic [LANES-1:0] bs_out,
  output logic             bs_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam logic [FRAME_LOG2-1:0] CNT_MAX = '1;

  logic [1:0]            rst_sync;
  logic                  rst_i;
  bsg_state_t            state;
  bsg_state_t            state_nx;
  logic [FRAME_LOG2-1:0] cnt;
  logic [DATA_W-1:0]     active;
  logic [DATA_W-1:0]     pend;
  logic                  pend_v;
  logic                  accept;
  logic                  step;
  logic                  frame_end;
  logic                  load;
  logic                  drain;
  logic                  to_pend;
  logic [DATA_W-1:0]     load_val;
  logic [LANES-1:0]      bits;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_i = rst_sync[1];

  assign src.in_ready = !pend_v;
  assign accept       = src.in_valid && !pend_v;
  assign step         = (state == RUN) && en;
  assign frame_end    = step && (cnt == CNT_MAX);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    drain    = 1'b0;
    to_pend  = 1'b0;
    load_val = src.in_data;
    unique case (state)
      IDLE: begin
        if (accept) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (pend_v) begin
            load     = 1'b1;
            drain    = 1'b1;
            load_val = pend;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          to_pend = accept;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      active <= '0;
      cnt    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
    end else begin
      if (load) begin
        active <= load_val;
        cnt    <= '0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
      if (to_pend) begin
        pend   <= src.in_data;
        pend_v <= 1'b1;
      end else if (drain) begin
        pend_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      bs_out      <= '0;
      bs_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      bs_valid    <= step;
      frame_start <= step && (cnt == '0);
      frame_done  <= frame_end;
      if (step) begin
        bs_out <= bits;
      end else if (state == IDLE) begin
        bs_out <= '0;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int unsigned PH_I = lane_phase(k, DATA_W, LANES);
    localparam logic [DATA_W-1:0] PH = PH_I[DATA_W-1:0];
    sd_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_i),
      .load   (load),
      .step   (step),
      .phase  (PH),
      .value  (active),
      .sample (bits[k])
    );
  end

endmodule
